riscv_lsu: RTL and testbench

RISCV_LSU -- requirements
Module: riscv_lsu

---
 rtl/riscv_lsu_pkg.sv | 66 ++++++
 rtl/riscv_lsu_align.sv | 52 +++++
 rtl/riscv_lsu.sv | 188 ++++++++++++++++++
 tb/tb_riscv_lsu.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// Load/store function codes, LSU FSM state type and small lane helpers shared by riscv_lsu.
package riscv_lsu_pkg;

    localparam int unsigned LD_FUNCT_W = 3;
    localparam int unsigned ST_FUNCT_W = 3;

    localparam logic [LD_FUNCT_W-1:0] LD_NONE = 3'd0;
    localparam logic [LD_FUNCT_W-1:0] LD_B    = 3'd1;
    localparam logic [LD_FUNCT_W-1:0] LD_H    = 3'd2;
    localparam logic [LD_FUNCT_W-1:0] LD_W    = 3'd3;
    localparam logic [LD_FUNCT_W-1:0] LD_BU   = 3'd4;
    localparam logic [LD_FUNCT_W-1:0] LD_HU   = 3'd5;
    localparam logic [LD_FUNCT_W-1:0] LD_WU   = 3'd6;
    localparam logic [LD_FUNCT_W-1:0] LD_D    = 3'd7;

    localparam logic [ST_FUNCT_W-1:0] ST_NONE = 3'd0;
    localparam logic [ST_FUNCT_W-1:0] ST_B    = 3'd1;
    localparam logic [ST_FUNCT_W-1:0] ST_H    = 3'd2;
    localparam logic [ST_FUNCT_W-1:0] ST_W    = 3'd3;
    localparam logic [ST_FUNCT_W-1:0] ST_D    = 3'd4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StRsp  = 2'd2
    } lsu_state_e;

    // Sizes are log2 of the access width in bytes.
    function automatic logic [1:0] ld_size(input logic [LD_FUNCT_W-1:0] funct);
        logic [1:0] size;
        case (funct)
            LD_H, LD_HU: size = 2'd1;
            LD_W, LD_WU: size = 2'd2;
            LD_D:        size = 2'd3;
            default:     size = 2'd0;
        endcase
        return size;
    endfunction

    function automatic logic ld_signed(input logic [LD_FUNCT_W-1:0] funct);
        return (funct == LD_B) || (funct == LD_H) || (funct == LD_W);
    endfunction

    function automatic logic [1:0] st_size(input logic [ST_FUNCT_W-1:0] funct);
        logic [1:0] size;
        case (funct)
            ST_H:    size = 2'd1;
            ST_W:    size = 2'd2;
            ST_D:    size = 2'd3;
            default: size = 2'd0;
        endcase
        return size;
    endfunction

    function automatic logic [2:0] size_mask(input logic [1:0] size);
        logic [2:0] mask;
        case (size)
            2'd1:    mask = 3'b001;
            2'd2:    mask = 3'b011;
            2'd3:    mask = 3'b111;
            default: mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: store mask/data shifting and load extraction with sign/zero extension.
// RISCV_LSU_MISALIGN_TRAP_EN undefined: misaligned offsets are truncated to natural alignment.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]                size,
    input  logic                      sext,
    input  logic [$clog2(XLEN/8)-1:0] offset,
    input  logic [XLEN-1:0]           st_data,
    input  logic [XLEN-1:0]           rdata,
    output logic [$clog2(XLEN/8)-1:0] lane_off,
    output logic [XLEN-1:0]           wdata,
    output logic [XLEN/8-1:0]         wmask,
    output logic [XLEN-1:0]           ld_data
);
    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(NB);

    logic [7:0]      base_mask;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] keep;
    logic            sbit;

    always_comb begin
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
        lane_off = offset;
`else
        lane_off = offset & ~OFF_W'(size_mask(size));
`endif
        case (size)
            2'd0:    base_mask = 8'h01;
            2'd1:    base_mask = 8'h03;
            2'd2:    base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
        wmask   = NB'(base_mask) << lane_off;
        wdata   = st_data << {lane_off, 3'b000};
        shifted = rdata >> {lane_off, 3'b000};

        // keep marks the loaded bytes; everything above is filled with the sign or zero
        case (size)
            2'd0:    begin keep = XLEN'(8'hFF);         sbit = shifted[7];      end
            2'd1:    begin keep = XLEN'(16'hFFFF);      sbit = shifted[15];     end
            2'd2:    begin keep = XLEN'(32'hFFFF_FFFF); sbit = shifted[31];     end
            default: begin keep = '1;                   sbit = shifted[XLEN-1]; end
        endcase
        ld_data = (shifted & keep) | ((sext && sbit) ? ~keep : '0);
    end

endmodule

// File: rtl/riscv_lsu.sv
// RISC-V load/store unit: sequences EX ops over a split request/response data bus.
// RISCV_LSU_MISALIGN_TRAP_EN: when defined, misaligned ops raise lsu_exc instead of a bus access.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  ex_lsu_rdy,
    output logic                  ex_lsu_ack,
    input  logic                  ex_lsu_alu_op,
    input  logic [LD_FUNCT_W-1:0] ex_lsu_ld_funct,
    input  logic [ST_FUNCT_W-1:0] ex_lsu_st_funct,
    input  logic [XLEN-1:0]       ex_lsu_st_data,
    input  logic [XLEN-1:0]       ex_lsu_data,
    output logic [ADDR_W-1:0]     data_bif_addr,
    output logic                  data_bif_rnw,
    output logic                  data_bif_rdy,
    input  logic                  data_bif_ack,
    output logic [XLEN-1:0]       data_bif_wdata,
    output logic [XLEN/8-1:0]     data_bif_wmask,
    input  logic                  data_bif_rvalid,
    input  logic [XLEN-1:0]       data_bif_rdata,
    output logic                  lsu_rf_rdy,
    output logic [XLEN-1:0]       lsu_rf_data,
    output logic                  lsu_exc,
    output logic [XLEN-1:0]       lsu_exc_addr
);
    localparam int unsigned OFF_W   = $clog2(XLEN / 8);
    localparam bit          IS_RV64 = (XLEN == 64);

    lsu_state_e          state_q, state_d;
    logic                is_ld, is_st, mem_op, trap;
    logic [1:0]          dec_size;
    logic                dec_sext;
    logic                rnw_q, sext_q;
    logic [1:0]          size_q;
    logic [OFF_W-1:0]    off_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [XLEN-1:0]     wdata_q;
    logic [XLEN/8-1:0]   wmask_q;
    logic                rf_rdy_q;
    logic [XLEN-1:0]     rf_data_q;
    logic [1:0]          al_size;
    logic                al_sext;
    logic [OFF_W-1:0]    al_off, lane_off;
    logic [XLEN-1:0]     al_wdata, al_ld_data;
    logic [XLEN/8-1:0]   al_wmask;

    // RV64-only codes are treated as non-memory ops on RV32; a load code wins over a store code
    always_comb begin
        is_ld    = (ex_lsu_ld_funct != LD_NONE) &&
                   (IS_RV64 || !(ex_lsu_ld_funct inside {LD_WU, LD_D}));
        is_st    = (ex_lsu_st_funct != ST_NONE) && (IS_RV64 || ex_lsu_st_funct != ST_D);
        mem_op   = is_ld || is_st;
        dec_size = is_ld ? ld_size(ex_lsu_ld_funct) : st_size(ex_lsu_st_funct);
        dec_sext = is_ld && ld_signed(ex_lsu_ld_funct);
    end

    always_comb begin
        if (state_q == StIdle) begin
            al_size = dec_size;
            al_sext = dec_sext;
            al_off  = ex_lsu_data[OFF_W-1:0];
        end else begin
            al_size = size_q;
            al_sext = sext_q;
            al_off  = off_q;
        end
    end

    riscv_lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .size    (al_size),
        .sext    (al_sext),
        .offset  (al_off),
        .st_data (ex_lsu_st_data),
        .rdata   (data_bif_rdata),
        .lane_off(lane_off),
        .wdata   (al_wdata),
        .wmask   (al_wmask),
        .ld_data (al_ld_data)
    );

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    logic            exc_q;
    logic [XLEN-1:0] exc_addr_q;

    assign trap = mem_op && ((3'(ex_lsu_data[OFF_W-1:0]) & size_mask(dec_size)) != 3'b000);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            exc_q      <= 1'b0;
            exc_addr_q <= '0;
        end else begin
            exc_q <= (state_q == StIdle) && ex_lsu_rdy && trap;
            if ((state_q == StIdle) && ex_lsu_rdy && trap) exc_addr_q <= ex_lsu_data;
        end
    end

    assign lsu_exc      = exc_q;
    assign lsu_exc_addr = exc_addr_q;
`else
    assign trap         = 1'b0;
    assign lsu_exc      = 1'b0;
    assign lsu_exc_addr = '0;
`endif

    always_comb begin
        state_d    = state_q;
        ex_lsu_ack = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ex_lsu_rdy) begin
                    if (mem_op && !trap) state_d = StReq;
                    else                 ex_lsu_ack = 1'b1;
                end
            end
            StReq: begin
                if (data_bif_ack) begin
                    if (rnw_q) begin
                        state_d = StRsp;
                    end else begin
                        state_d    = StIdle;
                        ex_lsu_ack = 1'b1;
                    end
                end
            end
            StRsp: begin
                if (data_bif_rvalid) begin
                    state_d    = StIdle;
                    ex_lsu_ack = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        // A cycle held in reset abandons the op, so it must not complete it either
        if (!rstn) ex_lsu_ack = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= StIdle;
            rnw_q     <= 1'b1;
            sext_q    <= 1'b0;
            size_q    <= 2'd0;
            off_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            rf_rdy_q  <= 1'b0;
            rf_data_q <= '0;
        end else begin
            state_q  <= state_d;
            rf_rdy_q <= 1'b0;
            if ((state_q == StIdle) && ex_lsu_rdy && !trap) begin
                if (mem_op) begin
                    rnw_q   <= is_ld;
                    sext_q  <= dec_sext;
                    size_q  <= dec_size;
                    off_q   <= lane_off;
                    addr_q  <= {ex_lsu_data[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    wdata_q <= al_wdata;
                    wmask_q <= al_wmask;
                end else begin
                    rf_rdy_q  <= ex_lsu_alu_op;
                    rf_data_q <= ex_lsu_data;
                end
            end
            if ((state_q == StRsp) && data_bif_rvalid) begin
                rf_rdy_q  <= 1'b1;
                rf_data_q <= al_ld_data;
            end
        end
    end

    assign data_bif_rdy   = (state_q == StReq);
    assign data_bif_rnw   = (state_q == StReq) ? rnw_q : 1'b1;
    assign data_bif_addr  = addr_q;
    assign data_bif_wdata = wdata_q;
    assign data_bif_wmask = wmask_q;
    assign lsu_rf_rdy     = rf_rdy_q;
    assign lsu_rf_data    = rf_data_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu (XLEN=64): directed cases plus randomized ops against a byte-arithmetic model.
// Expectations follow RISCV_LSU_MISALIGN_TRAP_EN when it is defined for the build.
module tb_riscv_lsu;
    import riscv_lsu_pkg::*;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned ADDR_W = 32;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  ex_lsu_rdy, ex_lsu_ack, ex_lsu_alu_op;
    logic [LD_FUNCT_W-1:0] ex_lsu_ld_funct;
    logic [ST_FUNCT_W-1:0] ex_lsu_st_funct;
    logic [XLEN-1:0]       ex_lsu_st_data, ex_lsu_data;
    logic [ADDR_W-1:0]     data_bif_addr;
    logic                  data_bif_rnw, data_bif_rdy, data_bif_ack, data_bif_rvalid;
    logic [XLEN-1:0]       data_bif_wdata, data_bif_rdata;
    logic [XLEN/8-1:0]     data_bif_wmask;
    logic                  lsu_rf_rdy, lsu_exc;
    logic [XLEN-1:0]       lsu_rf_data, lsu_exc_addr;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] last_rf, last_wdata, last_addr;
    logic [7:0]  last_mask;

    always #5 clk = ~clk;

    riscv_lsu #(
        .XLEN  (XLEN),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .ex_lsu_rdy     (ex_lsu_rdy),
        .ex_lsu_ack     (ex_lsu_ack),
        .ex_lsu_alu_op  (ex_lsu_alu_op),
        .ex_lsu_ld_funct(ex_lsu_ld_funct),
        .ex_lsu_st_funct(ex_lsu_st_funct),
        .ex_lsu_st_data (ex_lsu_st_data),
        .ex_lsu_data    (ex_lsu_data),
        .data_bif_addr  (data_bif_addr),
        .data_bif_rnw   (data_bif_rnw),
        .data_bif_rdy   (data_bif_rdy),
        .data_bif_ack   (data_bif_ack),
        .data_bif_wdata (data_bif_wdata),
        .data_bif_wmask (data_bif_wmask),
        .data_bif_rvalid(data_bif_rvalid),
        .data_bif_rdata (data_bif_rdata),
        .lsu_rf_rdy     (lsu_rf_rdy),
        .lsu_rf_data    (lsu_rf_data),
        .lsu_exc        (lsu_exc),
        .lsu_exc_addr   (lsu_exc_addr)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic int ld_bytes(input logic [2:0] f);
        case (f)
            LD_B, LD_BU: return 1;
            LD_H, LD_HU: return 2;
            LD_W, LD_WU: return 4;
            default:     return 8;
        endcase
    endfunction

    function automatic int st_bytes(input logic [2:0] f);
        case (f)
            ST_B:    return 1;
            ST_H:    return 2;
            ST_W:    return 4;
            default: return 8;
        endcase
    endfunction

    // Take n bytes starting at byte off, then extend to 64 bits.
    function automatic logic [63:0] extract(input logic [63:0] rd, input int off, input int n,
                                            input bit sgn);
        logic [63:0] v, lim;
        v = rd >> (8 * off);
        if (n == 8) return v;
        lim = 64'd1 << (8 * n);
        v   = v % lim;
        if (sgn && v >= lim / 2) v = v - lim;
        return v;
    endfunction

    task automatic run_op(input logic [2:0] ld, input logic [2:0] st, input logic alu,
                          input logic [63:0] data, input logic [63:0] sdata,
                          input logic [63:0] rdata, input int aw, input int rw, input string tag);
        bit          is_ld, is_mem, mis, sgn;
        int          n, off, m;
        logic [63:0] e_wdata, e_ld, e_addr;
        logic [7:0]  e_mask;
        is_ld  = (ld != LD_NONE);
        is_mem = is_ld || (st != ST_NONE);
        n      = is_ld ? ld_bytes(ld) : st_bytes(st);
        sgn    = is_ld && (ld == LD_B || ld == LD_H || ld == LD_W);
        off    = int'(data % 64'd8);
        mis    = is_mem && (off % n) != 0;
`ifndef RISCV_LSU_MISALIGN_TRAP_EN
        off = off - off % n;
        mis = 1'b0;
`endif
        e_addr  = (data % 64'h1_0000_0000) - (data % 64'd8);
        m       = ((1 << n) - 1) << off;
        e_mask  = 8'(m);
        e_wdata = sdata << (8 * off);
        e_ld    = extract(rdata, off, n, sgn);

        ex_lsu_rdy = 1'b1; ex_lsu_ld_funct = ld; ex_lsu_st_funct = st;
        ex_lsu_alu_op = alu; ex_lsu_data = data; ex_lsu_st_data = sdata;
        mid();
        if (!is_mem || mis) begin
            check_eq({tag, " ack"}, 64'(ex_lsu_ack), 64'd1);
            tick();
            ex_lsu_rdy = 1'b0;
            check_eq({tag, " bif_rdy"}, 64'(data_bif_rdy), 64'd0);
            if (mis) begin
                check_eq({tag, " exc"}, 64'(lsu_exc), 64'd1);
                check_eq({tag, " exc_addr"}, lsu_exc_addr, data);
                check_eq({tag, " rf_rdy"}, 64'(lsu_rf_rdy), 64'd0);
            end else begin
                check_eq({tag, " rf_rdy"}, 64'(lsu_rf_rdy), 64'(alu));
                if (alu) check_eq({tag, " rf_data"}, lsu_rf_data, data);
                check_eq({tag, " exc"}, 64'(lsu_exc), 64'd0);
                last_rf = lsu_rf_data;
            end
            tick();
            check_eq({tag, " rf_pulse"}, 64'(lsu_rf_rdy), 64'd0);
            check_eq({tag, " exc_pulse"}, 64'(lsu_exc), 64'd0);
            return;
        end
        check_eq({tag, " early_ack"}, 64'(ex_lsu_ack), 64'd0);
        tick();
        last_addr = 64'(data_bif_addr); last_mask = data_bif_wmask; last_wdata = data_bif_wdata;
        for (int i = 0; i <= aw; i++) begin
            check_eq({tag, " req_rdy"}, 64'(data_bif_rdy), 64'd1);
            check_eq({tag, " addr"}, 64'(data_bif_addr), e_addr);
            check_eq({tag, " rnw"}, 64'(data_bif_rnw), 64'(is_ld));
            check_eq({tag, " wmask"}, 64'(data_bif_wmask), 64'(e_mask));
            if (!is_ld) check_eq({tag, " wdata"}, data_bif_wdata, e_wdata);
            data_bif_rvalid = 1'($urandom_range(0, 1));
            data_bif_ack    = (i == aw);
            mid();
            check_eq({tag, " req_ack"}, 64'(ex_lsu_ack), 64'((i == aw) && !is_ld));
            tick();
            data_bif_ack = 1'b0; data_bif_rvalid = 1'b0;
        end
        if (!is_ld) begin
            ex_lsu_rdy = 1'b0;
            check_eq({tag, " st_done_rdy"}, 64'(data_bif_rdy), 64'd0);
            check_eq({tag, " idle_rnw"}, 64'(data_bif_rnw), 64'd1);
            check_eq({tag, " st_no_wb"}, 64'(lsu_rf_rdy), 64'd0);
            return;
        end
        for (int i = 0; i <= rw; i++) begin
            check_eq({tag, " rsp_rdy"}, 64'(data_bif_rdy), 64'd0);
            data_bif_ack    = 1'($urandom_range(0, 1));
            data_bif_rvalid = (i == rw);
            data_bif_rdata  = (i == rw) ? rdata : {$urandom, $urandom};
            mid();
            check_eq({tag, " rsp_ack"}, 64'(ex_lsu_ack), 64'(i == rw));
            tick();
            data_bif_ack = 1'b0; data_bif_rvalid = 1'b0;
        end
        ex_lsu_rdy = 1'b0;
        check_eq({tag, " ld_rf_rdy"}, 64'(lsu_rf_rdy), 64'd1);
        check_eq({tag, " ld_rf_data"}, lsu_rf_data, e_ld);
        last_rf = lsu_rf_data;
        tick();
        check_eq({tag, " ld_rf_pulse"}, 64'(lsu_rf_rdy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          kind;
        logic [2:0]  rld, rst;
        logic [63:0] rdat;
        rstn = 1'b0; ex_lsu_rdy = 1'b0; ex_lsu_alu_op = 1'b0;
        ex_lsu_ld_funct = LD_NONE; ex_lsu_st_funct = ST_NONE;
        ex_lsu_st_data = '0; ex_lsu_data = '0;
        data_bif_ack = 1'b0; data_bif_rvalid = 1'b0; data_bif_rdata = '0;
        tick(); tick();
        check_eq("rst ack", 64'(ex_lsu_ack), 64'd0);
        check_eq("rst bif_rdy", 64'(data_bif_rdy), 64'd0);
        check_eq("rst rnw", 64'(data_bif_rnw), 64'd1);
        check_eq("rst rf_rdy", 64'(lsu_rf_rdy), 64'd0);
        check_eq("rst exc", 64'(lsu_exc), 64'd0);
        check_eq("rst addr", 64'(data_bif_addr), 64'd0);
        check_eq("rst wmask", 64'(data_bif_wmask), 64'd0);
        check_eq("rst wdata", data_bif_wdata, 64'd0);
        check_eq("rst rf_data", lsu_rf_data, 64'd0);
        check_eq("rst exc_addr", lsu_exc_addr, 64'd0);
        rstn = 1'b1;
        tick();

        run_op(LD_NONE, ST_NONE, 1'b1, 64'h1234_5678, '0, '0, 0, 0, "alu");
        check_eq("alu value", last_rf, 64'h1234_5678);

        run_op(LD_B, ST_NONE, 1'b0, 64'h1003, '0, 64'h80AA_BBCC, 0, 1, "lb");
        check_eq("lb value", last_rf, 64'hFFFF_FFFF_FFFF_FF80);

        run_op(LD_NONE, ST_H, 1'b0, 64'h1002, 64'hDEAD_BEEF, '0, 3, 0, "sh");
        check_eq("sh mask", 64'(last_mask), 64'h0C);
        check_eq("sh wdata_lo", last_wdata % 64'h1_0000_0000, 64'hBEEF_0000);
        check_eq("sh addr", last_addr, 64'h1000);

        run_op(LD_W, ST_B, 1'b0, 64'h1001, '0, 64'h1122_3344_5566_7788, 1, 0, "lw_mis");
`ifndef RISCV_LSU_MISALIGN_TRAP_EN
        check_eq("lw_mis addr", last_addr, 64'h1000);
        check_eq("lw_mis value", last_rf, 64'h5566_7788);
`endif

        run_op(LD_WU, ST_NONE, 1'b0, 64'h4, '0, 64'h8000_0001_0000_0000, 0, 0, "lwu");
        check_eq("lwu value", last_rf, 64'h0000_0000_8000_0001);

        // Reset while waiting for the load response; a late rvalid must be ignored.
        ex_lsu_rdy = 1'b1; ex_lsu_ld_funct = LD_W; ex_lsu_st_funct = ST_NONE;
        ex_lsu_data = 64'h2000;
        tick();
        data_bif_ack = 1'b1;
        tick();
        data_bif_ack = 1'b0; rstn = 1'b0; ex_lsu_rdy = 1'b0; ex_lsu_ld_funct = LD_NONE;
        tick();
        rstn = 1'b1;
        check_eq("rstrsp bif_rdy", 64'(data_bif_rdy), 64'd0);
        data_bif_rvalid = 1'b1; data_bif_rdata = 64'hFFFF;
        mid();
        check_eq("rstrsp ack", 64'(ex_lsu_ack), 64'd0);
        tick();
        data_bif_rvalid = 1'b0;
        check_eq("rstrsp rf_rdy", 64'(lsu_rf_rdy), 64'd0);
        run_op(LD_NONE, ST_NONE, 1'b1, 64'hCAFE, '0, '0, 0, 0, "post_rst_alu");

        for (int k = 0; k < 60; k++) begin
            kind = int'($urandom_range(0, 2));
            rld  = LD_NONE;
            rst  = ST_NONE;
            if (kind == 1) begin
                rld = 3'($urandom_range(1, 7));
                rst = 3'($urandom_range(0, 4));
            end else if (kind == 2) begin
                rst = 3'($urandom_range(1, 4));
            end
            rdat = (kind == 0) ? {$urandom, $urandom} : 64'h1000 + 64'($urandom_range(0, 63));
            run_op(rld, rst, 1'($urandom_range(0, 1)), rdat, {$urandom, $urandom},
                   {$urandom, $urandom}, int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
